// File: rtl/pcie_msi_irq_moderator.sv
// Per-vector MSI interrupt moderation: rate-limits msi_irq pulses with a holdoff timer
// and coalesces events arriving during holdoff into one deferred pulse.
module pcie_msi_irq_moderator #(
    parameter int MSI_COUNT   = 32,
    parameter int INDEX_WIDTH = $clog2(MSI_COUNT),
    parameter int PRESCALE    = 250,
    parameter int TIME_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] in_irq_index,
    input  logic                   in_irq_valid,
    output logic                   in_irq_ready,
    output logic [MSI_COUNT-1:0]   msi_irq,
    input  logic                   cfg_enable,
    input  logic [TIME_WIDTH-1:0]  cfg_holdoff
);

    localparam int PS_W = $clog2(PRESCALE + 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic {IDLE, HOLDOFF} vstate_t;

    logic [PS_W-1:0]       prescale_q;
    logic                  tick;
    vstate_t               state_q [MSI_COUNT];
    vstate_t               state_d [MSI_COUNT];
    logic [TIME_WIDTH-1:0] timer_q [MSI_COUNT];
    logic [TIME_WIDTH-1:0] timer_d [MSI_COUNT];
    logic [MSI_COUNT-1:0]  pending_q;
    logic [MSI_COUNT-1:0]  pending_d;
    logic [MSI_COUNT-1:0]  fire;
    logic [MSI_COUNT-1:0]  ev;

    assign tick = (prescale_q == PS_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= '0;
        end else if (tick) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + PS_W'(1);
        end
    end

    // Out-of-range indices never match any vector, so they are accepted and dropped.
    always_comb begin
        for (int i = 0; i < MSI_COUNT; i++) begin
            ev[i] = in_irq_valid && in_irq_ready && cfg_enable &&
                    (in_irq_index == INDEX_WIDTH'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < MSI_COUNT; i++) begin
            state_d[i]   = state_q[i];
            timer_d[i]   = timer_q[i];
            pending_d[i] = pending_q[i];
            fire[i]      = 1'b0;
            if (!cfg_enable) begin
                state_d[i]   = IDLE;
                timer_d[i]   = '0;
                pending_d[i] = 1'b0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (ev[i]) begin
                            fire[i]    = 1'b1;
                            timer_d[i] = cfg_holdoff;
                            state_d[i] = HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        if (timer_q[i] != '0) begin
                            if (ev[i]) pending_d[i] = 1'b1;
                            if (tick)  timer_d[i]   = timer_q[i] - TIME_WIDTH'(1);
                        // A deferred pulse waits while a pulse is on the wire, keeping a low gap.
                        end else if (pending_q[i] && !msi_irq[i]) begin
                            fire[i]      = 1'b1;
                            pending_d[i] = ev[i];
                            timer_d[i]   = cfg_holdoff;
                        end else if (pending_q[i] || ev[i]) begin
                            pending_d[i] = 1'b1;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_irq_ready <= 1'b0;
            msi_irq      <= '0;
            pending_q    <= '0;
            for (int i = 0; i < MSI_COUNT; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            in_irq_ready <= 1'b1;
            msi_irq      <= fire;
            pending_q    <= pending_d;
            for (int i = 0; i < MSI_COUNT; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pcie_msi_irq_moderator.sv
// Bench for pcie_msi_irq_moderator: vector table with expected-output queue plus
// hand-written multi-cycle sequences for coalescing, spacing, disable and reset.
module tb_pcie_msi_irq_moderator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  in_irq_index = '0;
    logic        in_irq_valid = 1'b0;
    logic        in_irq_ready;
    logic [19:0] msi_irq;
    logic        cfg_enable = 1'b1;
    logic [15:0] cfg_holdoff = 16'd3;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        v;
        logic [4:0]  idx;
        logic [19:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    pcie_msi_irq_moderator #(
        .MSI_COUNT(20),
        .INDEX_WIDTH(5),
        .PRESCALE(4),
        .TIME_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_irq_index(in_irq_index),
        .in_irq_valid(in_irq_valid),
        .in_irq_ready(in_irq_ready),
        .msi_irq(msi_irq),
        .cfg_enable(cfg_enable),
        .cfg_holdoff(cfg_holdoff)
    );

    function automatic vec_t mk(input logic v, input logic [4:0] idx, input logic [19:0] exp);
        vec_t r;
        r.v = v;
        r.idx = idx;
        r.exp = exp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of input (starting #1 after a posedge) and return #1 after the next posedge.
    task automatic step(input logic v, input logic [4:0] idx);
        in_irq_valid = v;
        in_irq_index = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string name, input logic v, input logic [4:0] idx, input logic [19:0] exp);
        exp_q.push_back(exp);
        step(v, idx);
        check({name, "_msi"}, 32'(msi_irq), 32'(exp_q.pop_front()));
        check({name, "_rdy"}, 32'(in_irq_ready), 32'd1);
    endtask

    task automatic drain(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 5'd0);
        end
        check(name, 32'(msi_irq), 32'd0);
    endtask

    initial begin
        int pulses;
        int pos;
        int dbl;
        int any;
        logic prev;
        logic [19:0] other;

        tbl.push_back(mk(1'b1, 5'd5,  20'h00020));
        tbl.push_back(mk(1'b0, 5'd0,  20'h00000));
        tbl.push_back(mk(1'b0, 5'd0,  20'h00000));
        tbl.push_back(mk(1'b1, 5'd0,  20'h00001));
        tbl.push_back(mk(1'b1, 5'd19, 20'h80000));
        tbl.push_back(mk(1'b0, 5'd0,  20'h00000));
        tbl.push_back(mk(1'b1, 5'd25, 20'h00000));
        tbl.push_back(mk(1'b0, 5'd0,  20'h00000));
        tbl.push_back(mk(1'b1, 5'd12, 20'h01000));
        tbl.push_back(mk(1'b0, 5'd0,  20'h00000));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_msi", 32'(msi_irq), 32'd0);
        check("rst_rdy", 32'(in_irq_ready), 32'd0);
        rst = 1'b0;
        step(1'b0, 5'd0);
        check("rst_rel_rdy", 32'(in_irq_ready), 32'd1);

        // Single pulses, two vectors back to back, out-of-range index
        for (int k = 0; k < tbl.size(); k++) begin
            cyc($sformatf("tbl%0d", k), tbl[k].v, tbl[k].idx, tbl[k].exp);
        end
        drain("tbl_drain", 24);

        // Coalescing: events during holdoff give one deferred pulse in t+11..t+14
        step(1'b1, 5'd5);
        check("t2_first", 32'(msi_irq), 32'h20);
        pulses = 0;
        pos = 0;
        other = '0;
        for (int k = 1; k <= 44; k++) begin
            step((k >= 2 && k <= 4), 5'd5);
            other |= msi_irq & ~20'h00020;
            if (msi_irq[5]) begin
                pulses++;
                pos = k + 1;
            end
        end
        check("t2_count", 32'(pulses), 32'd1);
        check("t2_window", 32'(pos >= 11 && pos <= 14), 32'd1);
        check("t2_other", 32'(other), 32'd0);

        // Zero holdoff: max rate is one pulse every other cycle
        cfg_holdoff = 16'd0;
        dbl = 0;
        prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 5'd2);
            check($sformatf("t3_alt%0d", k), 32'(msi_irq), (k % 2 == 0) ? 32'h4 : 32'h0);
            if (prev && msi_irq[2]) dbl++;
            prev = msi_irq[2];
        end
        for (int k = 12; k < 24; k++) begin
            step(1'b0, 5'd2);
            if (prev && msi_irq[2]) dbl++;
            prev = msi_irq[2];
        end
        check("t3_no_double", 32'(dbl), 32'd0);
        cfg_holdoff = 16'd3;
        drain("t3_drain", 20);

        // Disable clears pending; re-enable pulses immediately
        step(1'b1, 5'd7);
        check("t5_first", 32'(msi_irq), 32'h80);
        step(1'b1, 5'd7);
        check("t5_pend", 32'(msi_irq), 32'd0);
        cfg_enable = 1'b0;
        any = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 5'd7);
            if (msi_irq != '0) any++;
        end
        check("t5_disabled", 32'(any), 32'd0);
        check("t5_dis_rdy", 32'(in_irq_ready), 32'd1);
        cfg_enable = 1'b1;
        step(1'b1, 5'd7);
        check("t5_reenable", 32'(msi_irq), 32'h80);
        drain("t5_drain", 20);

        // Reset mid-holdoff discards the pending event
        step(1'b1, 5'd9);
        check("t6_first", 32'(msi_irq), 32'h200);
        step(1'b1, 5'd9);
        check("t6_pend", 32'(msi_irq), 32'd0);
        rst = 1'b1;
        step(1'b0, 5'd0);
        check("t6_rst_msi", 32'(msi_irq), 32'd0);
        check("t6_rst_rdy", 32'(in_irq_ready), 32'd0);
        step(1'b0, 5'd0);
        check("t6_rst_rdy2", 32'(in_irq_ready), 32'd0);
        rst = 1'b0;
        step(1'b0, 5'd0);
        check("t6_rel_rdy", 32'(in_irq_ready), 32'd1);
        any = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 5'd0);
            if (msi_irq != '0) any++;
        end
        check("t6_no_deferred", 32'(any), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
